// File: rtl/pc_trace_buffer.sv
// Retired-instruction trace FIFO: captures {cycle, pc, instr} during a bounded
// window after reset and lets a consumer drain entries through a valid/ready port.
module pc_trace_buffer #(
  parameter int PC_W       = 32,
  parameter int INSTR_W    = 32,
  parameter int DEPTH      = 16,
  parameter int MAX_CYCLES = 40,
  parameter int WRAP       = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cap_en,
  input  logic [PC_W-1:0]        pc,
  input  logic [INSTR_W-1:0]     instr,
  input  logic                   rd_ready,
  output logic                   rd_valid,
  output logic [PC_W-1:0]        rd_pc,
  output logic [INSTR_W-1:0]     rd_instr,
  output logic [15:0]            rd_cycle,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty,
  output logic [15:0]            overflow_cnt,
  output logic                   done
);

  localparam int            AW      = $clog2(DEPTH);
  localparam int            EW      = 16 + PC_W + INSTR_W;
  localparam logic [15:0]   MAX_C   = 16'(MAX_CYCLES);
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
  localparam logic          WRAP_EN = (WRAP != 0);

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [15:0]   cycle;

  logic push_req;
  logic pop;
  logic lost;
  logic wr_en;
  logic head_adv;
  logic cnt_inc;
  logic cnt_dec;

  // Read port handshake: an entry transfers on any rising edge where
  // rd_valid and rd_ready are both 1; rd_valid never depends on rd_ready.
  assign empty    = (count == '0);
  assign full     = (count == DEPTH_C);
  assign rd_valid = ~empty;
  assign done     = (cycle == MAX_C);

  assign {rd_cycle, rd_pc, rd_instr} = mem[head];

  assign push_req = cap_en & ~done;
  assign pop      = rd_valid & rd_ready;
  // A push into a full buffer with no pop either overwrites the oldest entry
  // or is dropped; both count as a lost sample.
  assign lost     = push_req & full & ~pop;
  assign wr_en    = push_req & (~lost | WRAP_EN);
  assign head_adv = pop | (lost & WRAP_EN);
  assign cnt_inc  = push_req & ~full & ~pop;
  assign cnt_dec  = pop & ~push_req;

  always_ff @(posedge clk) begin
    if (!reset) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      cycle        <= '0;
      overflow_cnt <= '0;
    end else begin
      if (cycle != MAX_C) begin
        cycle <= cycle + 16'd1;
      end
      if (wr_en) begin
        tail <= tail + AW'(1);
      end
      if (head_adv) begin
        head <= head + AW'(1);
      end
      if (cnt_inc) begin
        count <= count + (AW+1)'(1);
      end else if (cnt_dec) begin
        count <= count - (AW+1)'(1);
      end
      if (lost && (overflow_cnt != 16'hFFFF)) begin
        overflow_cnt <= overflow_cnt + 16'd1;
      end
    end
  end

  // Storage is not reset; rd_valid hides whatever it holds until it is rewritten.
  always_ff @(posedge clk) begin
    if (reset && wr_en) begin
      mem[tail] <= {cycle, pc, instr};
    end
  end

endmodule
